regfile_scoreboard: RTL and testbench

// Parametrised integer register file with NUM_READ combinational read ports and one write port.

---
 rtl/regfile_scoreboard_if.sv | 29 ++
 rtl/regfile_scoreboard.sv | 99 +++++++++
 tb/tb_regfile_scoreboard.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the register file: read ports, writeback, issue and status.
// master = pipeline side, slave = register file side.
interface regfile_scoreboard_if #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_READ      = 2
);
  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0]    rd_data;
  logic [NUM_READ-1:0]               rd_busy;
  logic                              we;
  logic [ADDRESS_WIDTH-1:0]          wr_addr;
  logic [DATA_WIDTH-1:0]             wr_data;
  logic                              iss_valid;
  logic [ADDRESS_WIDTH-1:0]          iss_addr;
  logic                              iss_ready;
  logic [ADDRESS_WIDTH:0]            busy_count;
  logic [DATA_WIDTH-1:0]             dbg_data;

  modport master (
    output rd_addr, we, wr_addr, wr_data, iss_valid, iss_addr,
    input  rd_data, rd_busy, iss_ready, busy_count, dbg_data
  );

  modport slave (
    input  rd_addr, we, wr_addr, wr_data, iss_valid, iss_addr,
    output rd_data, rd_busy, iss_ready, busy_count, dbg_data
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with combinational read ports, optional write-to-read bypass and a
// per-register pending-write scoreboard for RAW/WAW hazard detection.
module regfile_scoreboard #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_READ      = 2,
  parameter int unsigned BYPASS        = 1,
  parameter int unsigned DEBUG_REG     = 10
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus_io
);

  localparam int unsigned Depth  = 2 ** ADDRESS_WIDTH;
  localparam int unsigned CountW = ADDRESS_WIDTH + 1;
  localparam bit          Fwd    = (BYPASS != 0);

  typedef logic [ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;
  typedef logic [CountW-1:0]        count_t;

  localparam addr_t DbgIdx = addr_t'(DEBUG_REG);

  data_t            regs_q [Depth];
  logic [Depth-1:0] busy_q, busy_d;
  count_t           busy_count_q, busy_count_d;

  logic wr_en;
  logic iss_fire;
  logic clr_busy;

  // Index 0 is hardwired: writes and issues to it are dropped here so it never changes.
  always_comb begin
    wr_en    = bus_io.we && (bus_io.wr_addr != '0);
    iss_fire = bus_io.iss_valid && (bus_io.iss_addr != '0) && !busy_q[bus_io.iss_addr];
    clr_busy = wr_en && busy_q[bus_io.wr_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < Depth; k++) begin
        regs_q[k] <= '0;
      end
    end else if (wr_en) begin
      regs_q[bus_io.wr_addr] <= bus_io.wr_data;
    end
  end

  // Clear first, then set: a same-edge issue to the written index leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[bus_io.wr_addr] = 1'b0;
    end
    if (iss_fire) begin
      busy_d[bus_io.iss_addr] = 1'b1;
    end
  end

  // A fire only targets a non-busy index, so a same-index writeback never also decrements.
  always_comb begin
    busy_count_d = busy_count_q;
    if (iss_fire && !clr_busy) begin
      busy_count_d = busy_count_q + count_t'(1);
    end else if (clr_busy && !iss_fire) begin
      busy_count_d = busy_count_q - count_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    addr_t ra;
    logic  fwd;
    assign ra  = bus_io.rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    // Forwarding is suppressed during reset so reads stay at zero.
    assign fwd = Fwd && !rst && wr_en && (bus_io.wr_addr == ra);
    assign bus_io.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = fwd ? bus_io.wr_data : regs_q[ra];
    assign bus_io.rd_busy[i] = busy_q[ra] && !fwd;
  end

  assign bus_io.iss_ready  = !busy_q[bus_io.iss_addr];
  assign bus_io.busy_count = busy_count_q;
  assign bus_io.dbg_data   = regs_q[DbgIdx];

  a_count_popcount: assert property (@(posedge clk) disable iff (rst)
    int'(busy_count_q) == $countones(busy_q));
  a_zero_never_busy: assert property (@(posedge clk) disable iff (rst) !busy_q[0]);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a bypass and a non-bypass instance share one stimulus stream
// and are compared against a table of hand-derived vectors and an array-based reference model.
module tb_regfile_scoreboard;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR*AW-1:0] rd_addr;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          iss_valid;
  logic [AW-1:0] iss_addr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) if_b1 ();
  regfile_scoreboard_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) if_b0 ();

  assign if_b1.rd_addr = rd_addr;    assign if_b0.rd_addr = rd_addr;
  assign if_b1.we = we;              assign if_b0.we = we;
  assign if_b1.wr_addr = wr_addr;    assign if_b0.wr_addr = wr_addr;
  assign if_b1.wr_data = wr_data;    assign if_b0.wr_data = wr_data;
  assign if_b1.iss_valid = iss_valid; assign if_b0.iss_valid = iss_valid;
  assign if_b1.iss_addr = iss_addr;  assign if_b0.iss_addr = iss_addr;

  regfile_scoreboard #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .BYPASS(1), .DEBUG_REG(10)
  ) dut_b1 (.clk(clk), .rst(rst), .bus_io(if_b1));

  regfile_scoreboard #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .BYPASS(0), .DEBUG_REG(10)
  ) dut_b0 (.clk(clk), .rst(rst), .bus_io(if_b0));

  // Reference model: architectural contents and pending-write flags.
  logic [DW-1:0] m_mem [32];
  bit            m_busy [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      m_mem[k]  = '0;
      m_busy[k] = 1'b0;
    end
  endtask

  function automatic bit fwd_hit(int a, bit byp);
    return byp && !rst && we && (a != 0) && (int'(wr_addr) == a);
  endfunction

  function automatic logic [31:0] m_rd(int a, bit byp);
    if (a == 0) return '0;
    if (fwd_hit(a, byp)) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit m_bsy(int a, bit byp);
    if (a == 0 || fwd_hit(a, byp)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < 32; k++) c += int'(m_busy[k]);
    return c;
  endfunction

  task automatic model_edge();
    bit fire;
    fire = iss_valid && (iss_addr != '0) && !m_busy[iss_addr];
    if (!rst) begin
      if (we && wr_addr != '0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (fire) m_busy[iss_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all();
    for (int b = 0; b < 2; b++) begin
      logic [NR*DW-1:0] rdd;
      logic [NR-1:0]    rbs;
      logic             rdy;
      logic [AW:0]      cnt;
      logic [DW-1:0]    dbg;
      if (b == 1) begin
        rdd = if_b1.rd_data; rbs = if_b1.rd_busy; rdy = if_b1.iss_ready;
        cnt = if_b1.busy_count; dbg = if_b1.dbg_data;
      end else begin
        rdd = if_b0.rd_data; rbs = if_b0.rd_busy; rdy = if_b0.iss_ready;
        cnt = if_b0.busy_count; dbg = if_b0.dbg_data;
      end
      for (int p = 0; p < NR; p++) begin
        int a;
        a = int'(rd_addr[p*AW +: AW]);
        chk($sformatf("byp%0d rd_data[%0d]", b, p), rdd[p*DW +: DW], m_rd(a, b == 1));
        chk($sformatf("byp%0d rd_busy[%0d]", b, p), 32'(rbs[p]), 32'(m_bsy(a, b == 1)));
      end
      chk($sformatf("byp%0d iss_ready", b), 32'(rdy), 32'(!m_busy[iss_addr]));
      chk($sformatf("byp%0d busy_count", b), 32'(cnt), 32'(m_count()));
      chk($sformatf("byp%0d dbg_data", b), dbg, m_mem[10]);
    end
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  typedef struct {
    bit          we;
    int          wa;
    logic [31:0] wd;
    bit          iv;
    int          ia;
    int          ra0;
    int          ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1_b1;
    logic [31:0] e_rd1_b0;
    bit          e_bsy1_b1;
    bit          e_bsy1_b0;
    bit          e_ready;
    int          e_count;
    logic [31:0] e_dbg;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    // we wa wd iv ia ra0 ra1 | rd0(b1) rd1(b1) rd1(b0) bsy1(b1) bsy1(b0) ready count dbg
    tbl[0]  = '{1, 10, DB,           0, 0, 10, 10, DB,       DB,       0,        0, 0, 1, 0, 0};
    tbl[1]  = '{0, 0,  0,            0, 0, 10, 0,  DB,       0,        0,        0, 0, 1, 0, DB};
    tbl[2]  = '{1, 0,  32'hFFFF_FFFF, 1, 0, 0,  0,  0,        0,        0,        0, 0, 1, 0, DB};
    tbl[3]  = '{0, 0,  0,            0, 0, 0,  0,  0,        0,        0,        0, 0, 1, 0, DB};
    tbl[4]  = '{1, 5,  32'h1111,     0, 0, 5,  5,  32'h1111, 32'h1111, 0,        0, 0, 1, 0, DB};
    tbl[5]  = '{1, 5,  32'h1234,     0, 0, 0,  5,  0,        32'h1234, 32'h1111, 0, 0, 1, 0, DB};
    tbl[6]  = '{0, 0,  0,            1, 7, 5,  7,  32'h1234, 0,        0,        0, 0, 1, 0, DB};
    tbl[7]  = '{0, 0,  0,            0, 7, 0,  7,  0,        0,        0,        1, 1, 0, 1, DB};
    tbl[8]  = '{1, 7,  32'hABCD,     1, 7, 0,  7,  0,        32'hABCD, 0,        0, 1, 0, 1, DB};
    tbl[9]  = '{1, 7,  32'h5555,     1, 7, 0,  7,  0,        32'h5555, 32'hABCD, 0, 0, 1, 0, DB};
    tbl[10] = '{0, 0,  0,            0, 7, 0,  7,  0,        32'h5555, 32'h5555, 1, 1, 0, 1, DB};
    tbl[11] = '{1, 7,  32'h7777,     0, 7, 0,  7,  0,        32'h7777, 32'h5555, 0, 1, 0, 1, DB};
    tbl[12] = '{0, 0,  0,            0, 7, 0,  7,  0,        32'h7777, 32'h7777, 0, 0, 1, 0, DB};

    rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; iss_valid = 1'b0; iss_addr = '0;
    set_rd(0, 10, 31);
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int r = 0; r < 13; r++) begin
      we = tbl[r].we; wr_addr = AW'(tbl[r].wa); wr_data = tbl[r].wd;
      iss_valid = tbl[r].iv; iss_addr = AW'(tbl[r].ia);
      set_rd(tbl[r].ra0, tbl[r].ra1, 0);
      @(negedge clk);
      chk($sformatf("vec%0d rd_data[0]", r), if_b1.rd_data[0 +: DW], tbl[r].e_rd0);
      chk($sformatf("vec%0d byp1 rd_data[1]", r), if_b1.rd_data[DW +: DW], tbl[r].e_rd1_b1);
      chk($sformatf("vec%0d byp0 rd_data[1]", r), if_b0.rd_data[DW +: DW], tbl[r].e_rd1_b0);
      chk($sformatf("vec%0d byp1 rd_busy[1]", r), 32'(if_b1.rd_busy[1]), 32'(tbl[r].e_bsy1_b1));
      chk($sformatf("vec%0d byp0 rd_busy[1]", r), 32'(if_b0.rd_busy[1]), 32'(tbl[r].e_bsy1_b0));
      chk($sformatf("vec%0d iss_ready", r), 32'(if_b1.iss_ready), 32'(tbl[r].e_ready));
      chk($sformatf("vec%0d busy_count", r), 32'(if_b0.busy_count), 32'(tbl[r].e_count));
      chk($sformatf("vec%0d dbg_data", r), if_b1.dbg_data, tbl[r].e_dbg);
      tick();
    end

    // Fill the scoreboard, then reset asynchronously between edges.
    we = 1'b0;
    for (int i = 1; i < 32; i++) begin
      iss_valid = 1'b1; iss_addr = AW'(i);
      tick();
    end
    iss_valid = 1'b0; iss_addr = AW'(3);
    @(negedge clk);
    chk("full busy_count byp1", 32'(if_b1.busy_count), 32'd31);
    chk("full busy_count byp0", 32'(if_b0.busy_count), 32'd31);
    check_all();
    set_rd(10, 10, 10);
    we = 1'b1; wr_addr = AW'(10); wr_data = 32'h1234_5678;
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async rst rd_data byp1", 32'(if_b1.rd_data != '0), 32'd0);
    chk("async rst rd_data byp0", 32'(if_b0.rd_data != '0), 32'd0);
    chk("async rst rd_busy", 32'({if_b1.rd_busy, if_b0.rd_busy}), 32'd0);
    chk("async rst iss_ready", 32'({if_b1.iss_ready, if_b0.iss_ready}), 32'd3);
    chk("async rst busy_count byp1", 32'(if_b1.busy_count), 32'd0);
    chk("async rst dbg_data", if_b1.dbg_data, 32'd0);
    check_all();
    #1;
    rst = 1'b0;
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("post-rst write dbg_data", if_b0.dbg_data, 32'h1234_5678);
    check_all();
    tick();

    // All ports on one index return the same stored value.
    we = 1'b1; wr_addr = AW'(3); wr_data = 32'hCAFE_F00D;
    tick();
    we = 1'b0;
    set_rd(3, 3, 3);
    @(negedge clk);
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("same-index byp1 port%0d", p), if_b1.rd_data[p*DW +: DW], 32'hCAFE_F00D);
      chk($sformatf("same-index byp0 port%0d", p), if_b0.rd_data[p*DW +: DW], 32'hCAFE_F00D);
    end
    tick();

    // Random traffic against the reference model, with occasional mid-cycle resets.
    for (int c = 0; c < 10000; c++) begin
      we        = 1'($urandom_range(0, 1));
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = $urandom;
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        int a;
        a = int'($urandom_range(0, 15));
        set_rd(a, a, a);
      end else begin
        set_rd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 31)));
      end
      @(negedge clk);
      check_all();
      if ($urandom_range(0, 999) == 0) begin
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
